// File: rtl/box_avg_pkg.sv
// Shared constants, beat control payload and width/reciprocal helpers for the
// KxK box-mean filter.
package box_avg_pkg;

  localparam int unsigned LAT = 5;

  // Control bits that travel alongside a window beat through the pipeline.
  typedef struct packed {
    logic vld;
    logic last;
    logic k5;
  } beat_ctl_t;

  function automatic int unsigned colsum_w(input int unsigned dw);
    return dw + 3;
  endfunction

  function automatic int unsigned hsum_w(input int unsigned dw);
    return dw + 5;
  endfunction

  function automatic int unsigned prod_w(input int unsigned in_w, input int unsigned shift);
    return in_w + shift;
  endfunction

  // ceil(2^shift / k^2)
  function automatic longint unsigned recip(input int unsigned k, input int unsigned shift);
    longint unsigned num;
    longint unsigned den;
    num = 64'd1 << shift;
    den = 64'(k) * 64'(k);
    return (num + den - 64'd1) / den;
  endfunction

endpackage

// File: rtl/box_avg_kxk_div.sv
// Constant-reciprocal divider: registers hsum*recip (P4) and the truncated
// quotient (P5) together with valid/last.
module const_div_recip
  import box_avg_pkg::*;
#(
  parameter int unsigned      IN_W    = 14,
  parameter int unsigned      OUT_W   = 9,
  parameter int unsigned      SHIFT   = 20,
  parameter longint unsigned  RECIP_A = recip(3, 20),
  parameter longint unsigned  RECIP_B = recip(5, 20)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  beat_ctl_t         in_ctl,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  output logic              out_last,
  output logic [OUT_W-1:0]  out_data
);

  localparam int unsigned      PROD_W = prod_w(IN_W, SHIFT);
  localparam logic [SHIFT-1:0] RA     = SHIFT'(RECIP_A);
  localparam logic [SHIFT-1:0] RB     = SHIFT'(RECIP_B);

  logic [PROD_W-1:0] prod_q, prod_d;
  logic              p4_vld_q, p4_vld_d;
  logic              p4_last_q, p4_last_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;

  always_comb begin
    prod_d      = prod_q;
    p4_vld_d    = in_ctl.vld;
    p4_last_d   = in_ctl.vld & in_ctl.last;
    out_valid_d = p4_vld_q;
    out_last_d  = p4_last_q;
    out_data_d  = out_data_q;
    if (in_ctl.vld) prod_d = PROD_W'(in_data) * PROD_W'(in_ctl.k5 ? RB : RA);
    if (p4_vld_q)   out_data_d = OUT_W'(prod_q >> SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q      <= '0;
      p4_vld_q    <= 1'b0;
      p4_last_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      prod_q      <= prod_d;
      p4_vld_q    <= p4_vld_d;
      p4_last_q   <= p4_last_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/box_avg_kxk.sv
// KxK (3x3 or 5x5) box mean over a column-streamed image with horizontal edge
// replication and an in_ready-gated right-edge flush.
module box_avg_kxk
  import box_avg_pkg::*;
#(
  parameter int unsigned DW    = 9,
  parameter int unsigned MAX_K = 5,
  parameter int unsigned SHIFT = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                win5,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                line_start,
  input  logic                line_end,
  input  logic [MAX_K*DW-1:0] col_in,
  output logic                out_valid,
  output logic [DW-1:0]       out_data,
  output logic                out_last
);

  localparam int unsigned CS_W   = colsum_w(DW);
  localparam int unsigned HS_W   = hsum_w(DW);
  localparam int unsigned MAX_R  = MAX_K / 2;
  localparam int unsigned CNT_W  = $clog2(MAX_R + 1);
  localparam int          CTR    = int'(MAX_K / 2);
  localparam logic        HAS_K5 = (MAX_K == 32'd5);

  function automatic logic [CNT_W-1:0] r_of(input logic k5);
    return k5 ? CNT_W'(MAX_R) : CNT_W'(1);
  endfunction

  logic [DW-1:0]    rows [MAX_K];
  logic             acc, start, k5_in, k_sel;
  logic [CS_W-1:0]  colsum_c;
  logic [CNT_W-1:0] idx, cnt_next;

  logic             in_ready_q, in_ready_d;
  logic             in_line_q, in_line_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CS_W-1:0]  colsum_q, colsum_d;
  logic             p1_shift_q, p1_shift_d;
  logic             p1_start_q, p1_start_d;
  beat_ctl_t        p1_ctl_q, p1_ctl_d;
  logic [CS_W-1:0]  win_q [MAX_K];
  logic [CS_W-1:0]  win_d [MAX_K];
  beat_ctl_t        p2_ctl_q, p2_ctl_d;
  logic [HS_W-1:0]  hsum_q, hsum_d;
  beat_ctl_t        p3_ctl_q, p3_ctl_d;

  for (genvar g = 0; g < MAX_K; g++) begin : g_rows
    assign rows[g] = col_in[g*DW +: DW];
  end

  assign acc   = in_valid & in_ready_q;
  assign start = acc & line_start;
  assign k5_in = HAS_K5 & win5;
  assign k_sel = start ? k5_in : mode_q;

  // P1 column sum over the active rows (centre +-1 in 3x3 mode)
  always_comb begin
    colsum_c = '0;
    for (int r = 0; r < int'(MAX_K); r++) begin
      if (k_sel || (r >= CTR - 1 && r <= CTR + 1)) colsum_c = colsum_c + CS_W'(rows[r]);
    end
  end

  // Beat sequencing: accepted beats, right-edge flush beats, output decision
  always_comb begin
    mode_d      = mode_q;
    in_line_d   = in_line_q;
    cnt_d       = cnt_q;
    flush_cnt_d = flush_cnt_q;
    colsum_d    = colsum_q;
    p1_shift_d  = 1'b0;
    p1_start_d  = 1'b0;
    p1_ctl_d    = '0;
    idx         = start ? '0 : cnt_q;
    cnt_next    = (cnt_q == CNT_W'(MAX_R)) ? cnt_q : cnt_q + CNT_W'(1);

    if (flush_cnt_q != '0) begin
      p1_shift_d    = 1'b1;
      p1_ctl_d.vld  = (cnt_q >= r_of(mode_q));
      p1_ctl_d.last = (flush_cnt_q == CNT_W'(1));
      p1_ctl_d.k5   = mode_q;
      cnt_d         = cnt_next;
      flush_cnt_d   = flush_cnt_q - CNT_W'(1);
    end else if (start || (acc && in_line_q)) begin
      p1_shift_d   = 1'b1;
      p1_start_d   = start;
      colsum_d     = colsum_c;
      p1_ctl_d.vld = (idx >= r_of(k_sel));
      p1_ctl_d.k5  = k_sel;
      mode_d       = k_sel;
      in_line_d    = 1'b1;
      cnt_d        = start ? CNT_W'(1) : cnt_next;
      if (line_end) begin
        in_line_d   = 1'b0;
        flush_cnt_d = r_of(k_sel);
      end
    end

    in_ready_d = (flush_cnt_d == '0);
  end

  // P2 window: full replication on line start, else shift in newest colsum
  always_comb begin
    win_d    = win_q;
    p2_ctl_d = p1_ctl_q;
    if (p1_shift_q) begin
      for (int i = int'(MAX_K) - 1; i > 0; i--) begin
        win_d[i] = p1_start_q ? colsum_q : win_q[i-1];
      end
      win_d[0] = colsum_q;
    end
  end

  // P3 horizontal sum over the newest K window entries
  always_comb begin
    hsum_d   = hsum_q;
    p3_ctl_d = p2_ctl_q;
    if (p2_ctl_q.vld) begin
      hsum_d = '0;
      for (int i = 0; i < int'(MAX_K); i++) begin
        if (i < 3 || p2_ctl_q.k5) hsum_d = hsum_d + HS_W'(win_q[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      in_line_q   <= 1'b0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      flush_cnt_q <= '0;
      colsum_q    <= '0;
      p1_shift_q  <= 1'b0;
      p1_start_q  <= 1'b0;
      p1_ctl_q    <= '0;
      for (int i = 0; i < int'(MAX_K); i++) win_q[i] <= '0;
      p2_ctl_q    <= '0;
      hsum_q      <= '0;
      p3_ctl_q    <= '0;
    end else begin
      in_ready_q  <= in_ready_d;
      in_line_q   <= in_line_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      flush_cnt_q <= flush_cnt_d;
      colsum_q    <= colsum_d;
      p1_shift_q  <= p1_shift_d;
      p1_start_q  <= p1_start_d;
      p1_ctl_q    <= p1_ctl_d;
      win_q       <= win_d;
      p2_ctl_q    <= p2_ctl_d;
      hsum_q      <= hsum_d;
      p3_ctl_q    <= p3_ctl_d;
    end
  end

  assign in_ready = in_ready_q;

  const_div_recip #(
    .IN_W    (HS_W),
    .OUT_W   (DW),
    .SHIFT   (SHIFT),
    .RECIP_A (recip(3, SHIFT)),
    .RECIP_B (recip(5, SHIFT))
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_ctl    (p3_ctl_q),
    .in_data   (hsum_q),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data)
  );

endmodule

// File: tb/tb_box_avg_kxk.sv
// Directed bench for box_avg_kxk: hand-computed means, edge flush timing,
// W=1 lines, in_valid gaps and asynchronous reset during flush.
module tb_box_avg_kxk;

  localparam int unsigned DW    = 9;
  localparam int unsigned MAX_K = 5;
  localparam int unsigned SHIFT = 20;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                win5;
  logic                in_valid;
  logic                in_ready;
  logic                line_start;
  logic                line_end;
  logic [MAX_K*DW-1:0] col_in;
  logic                out_valid;
  logic [DW-1:0]       out_data;
  logic                out_last;

  box_avg_kxk #(.DW(DW), .MAX_K(MAX_K), .SHIFT(SHIFT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .win5       (win5),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .line_start (line_start),
    .line_end   (line_end),
    .col_in     (col_in),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] od [$];
  logic          ol [$];
  int            oc [$];
  int            exp_v [$];

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      od.push_back(out_data);
      ol.push_back(out_last);
      oc.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int beat_cyc = 0;
  int b1_cyc   = 0;
  int g;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [31:0] od_at(input int i);
    return (i < od.size()) ? 32'(od[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ol_at(input int i);
    return (i < ol.size()) ? 32'(ol[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [MAX_K*DW-1:0] col_rows(input int r0, r1, r2, r3, r4);
    logic [MAX_K*DW-1:0] c;
    c[0*DW +: DW] = DW'(r0);
    c[1*DW +: DW] = DW'(r1);
    c[2*DW +: DW] = DW'(r2);
    c[3*DW +: DW] = DW'(r3);
    c[4*DW +: DW] = DW'(r4);
    return c;
  endfunction

  function automatic logic [MAX_K*DW-1:0] col_all(input int v);
    return col_rows(v, v, v, v, v);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One invalid cycle with junk on the data/control lines
  task automatic gap();
    in_valid   = 1'b0;
    line_start = 1'($urandom_range(0, 1));
    col_in     = col_all(int'($urandom_range(0, 511)));
    @(posedge clk);
    #1;
    line_start = 1'b0;
  endtask

  task automatic send(input logic [MAX_K*DW-1:0] col, input logic ls, input logic le,
                      input logic k5);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 10) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 10) begin
      n_checks++;
      $error("FAIL ready_timeout: observed in_ready %0b required 1", in_ready);
    end
    col_in     = col;
    line_start = ls;
    line_end   = le;
    win5       = k5;
    in_valid   = 1'b1;
    beat_cyc   = cyc;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    line_start = 1'b0;
    line_end   = 1'b0;
  endtask

  task automatic clear_out();
    od.delete();
    ol.delete();
    oc.delete();
  endtask

  task automatic check_line(input string tag);
    check({tag, "_count"}, 32'(od.size()), 32'(exp_v.size()));
    for (int i = 0; i < exp_v.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), od_at(i), 32'(exp_v[i]));
      check($sformatf("%s_last%0d", tag, i), ol_at(i), 32'(i == exp_v.size() - 1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    win5       = 1'b0;
    in_valid   = 1'b0;
    line_start = 1'b0;
    line_end   = 1'b0;
    col_in     = '0;
    idle(2);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;
    idle(1);

    // Junk beat before any line_start must not produce output
    clear_out();
    send(col_all(300), 1'b0, 1'b0, 1'b0);

    // 3x3, W=8, flat 100
    for (int i = 0; i < 8; i++) begin
      send(col_all(100), i == 0, i == 7, 1'b0);
      if (i == 1) b1_cyc = beat_cyc;
    end
    idle(12);
    exp_v = {100, 100, 100, 100, 100, 100, 100, 100};
    check_line("flat3");
    check("flat3_latency", 32'(((oc.size() > 0) ? oc[0] : 0) - b1_cyc), 32'd5);

    // 5x5, W=6, ramp 0..125 step 25
    clear_out();
    for (int i = 0; i < 6; i++) send(col_all(25 * i), i == 0, i == 5, 1'b1);
    check("ramp5_flush_rdy0", 32'(in_ready), 32'd0);
    idle(1);
    check("ramp5_flush_rdy1", 32'(in_ready), 32'd0);
    idle(1);
    check("ramp5_flush_rdy2", 32'(in_ready), 32'd1);
    idle(12);
    exp_v = {15, 30, 50, 75, 95, 110};
    check_line("ramp5");

    // 3x3, W=4, full scale
    clear_out();
    for (int i = 0; i < 4; i++) send(col_all(511), i == 0, i == 3, 1'b0);
    idle(12);
    exp_v = {511, 511, 511, 511};
    check_line("max3");

    // 3x3, W=1; outer rows must be excluded
    clear_out();
    send(col_rows(500, 9, 18, 27, 500), 1'b1, 1'b1, 1'b0);
    check("w1_flush_rdy0", 32'(in_ready), 32'd0);
    idle(1);
    check("w1_flush_rdy1", 32'(in_ready), 32'd1);
    idle(12);
    exp_v = {18};
    check_line("w1");

    // 5x5 ramp 10..50, gapless then with random in_valid gaps
    clear_out();
    for (int i = 0; i < 5; i++) send(col_all(10 * (i + 1)), i == 0, i == 4, 1'b1);
    idle(12);
    exp_v = {16, 22, 30, 38, 44};
    check_line("gapless5");

    clear_out();
    for (int i = 0; i < 5; i++) begin
      g = 0;
      while ($urandom_range(0, 1) == 1 && g < 4) begin
        gap();
        g++;
      end
      send(col_all(10 * (i + 1)), i == 0, i == 4, 1'b1);
    end
    idle(12);
    check_line("gapped5");

    // Async reset during a 5x5 flush, then a clean 3x3 line
    clear_out();
    for (int i = 0; i < 3; i++) send(col_all(200), i == 0, i == 2, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_flush_rdy",   32'(in_ready),  32'd1);
    check("rst_mid_flush_valid", 32'(out_valid), 32'd0);
    idle(2);
    rst_n = 1'b1;
    clear_out();
    idle(1);
    for (int i = 0; i < 4; i++) send(col_all(60), i == 0, i == 3, 1'b0);
    idle(12);
    exp_v = {60, 60, 60, 60};
    check_line("post_rst3");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
